sram_pingpong_buffer: RTL

Double-buffered (ping-pong) SRAM with byte-enable writes, built as the next generation of the single-port behavioural SRAM. A producer fills one bank while a consumer reads the other, and bank ownership swaps through a done/ready handshake on each side. It sits between a tile/DMA producer and a compute consumer so that load and compute overlap. Each bank is a behavioural array that physical design can replace with a memory-compiler macro.

---
 rtl/sram_pingpong_buffer_if.sv | 35 +++
 rtl/sram_pingpong_buffer.sv | 79 +++++++
 2 files changed

// File: rtl/sram_pingpong_buffer_if.sv
// Producer/consumer bus of the ping-pong buffer: write side, read side, status and errors.
interface sram_pingpong_buffer_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH/8-1:0] wr_be;
  logic               wr_done;
  logic               wr_ready;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic               rd_done;
  logic               rd_ready;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_valid;
  logic [1:0]         full_cnt;
  logic [1:0]         err;
  logic               err_clr;

  // Producer/consumer side drives strobes, observes status.
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, wr_done, rd_en, rd_addr, rd_done, err_clr,
    input  wr_ready, rd_ready, rd_data, rd_valid, full_cnt, err
  );

  // Buffer side.
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, wr_done, rd_en, rd_addr, rd_done, err_clr,
    output wr_ready, rd_ready, rd_data, rd_valid, full_cnt, err
  );
endinterface

// File: rtl/sram_pingpong_buffer.sv
// Double-buffered SRAM: producer fills one bank while the consumer drains the other.
// Bank ownership swaps on accepted wr_done / rd_done. Bank arrays are behavioural
// and carry no reset so they can be swapped for memory-compiler macros.
module sram_pingpong_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 256
) (
  input logic                   clk,
  input logic                   rst_n,
  sram_pingpong_buffer_if.slave bus
);
  localparam int unsigned NB = WIDTH / 8;

  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, rd_sel_q;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] mem [2][DEPTH];

  logic wr_ready, rd_ready;
  logic wr_acc, wr_done_acc, rd_acc, rd_done_acc;

  assign wr_ready    = !full_q[wr_sel_q];
  assign rd_ready    = full_q[rd_sel_q];
  assign wr_acc      = bus.wr_en && wr_ready;
  assign wr_done_acc = bus.wr_done && wr_ready;
  assign rd_acc      = bus.rd_en && rd_ready;
  assign rd_done_acc = bus.rd_done && rd_ready;

  assign bus.wr_ready = wr_ready;
  assign bus.rd_ready = rd_ready;
  assign bus.full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign bus.err      = err_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  // Next bank-full flags and sticky error bits.
  always_comb begin
    full_d = full_q;
    err_d  = err_q;
    // The two dones can never hit the same bank: fill bank is empty, drain bank is full.
    if (wr_done_acc) full_d[wr_sel_q] = 1'b1;
    if (rd_done_acc) full_d[rd_sel_q] = 1'b0;
    if (bus.err_clr) err_d = 2'b00;
    // A new error in the same cycle as err_clr keeps its bit set.
    if ((bus.wr_en || bus.wr_done) && !wr_ready) err_d[0] = 1'b1;
    if ((bus.rd_en || bus.rd_done) && !rd_ready) err_d[1] = 1'b1;
  end

  // Control state and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 2'b00;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      err_q      <= 2'b00;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      err_q      <= err_d;
      rd_valid_q <= rd_acc;
      if (wr_done_acc) wr_sel_q <= !wr_sel_q;
      if (rd_done_acc) rd_sel_q <= !rd_sel_q;
      // A read coincident with rd_done still uses the old bank.
      if (rd_acc) rd_data_q <= mem[rd_sel_q][bus.rd_addr];
    end
  end

  // Byte-masked write into the current fill bank; a coincident wr_done still uses it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_acc && bus.wr_be[i]) begin
        mem[wr_sel_q][bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end
endmodule
